clause_loader: RTL and testbench
================================

Name: clause_loader

Overview:
- Write-side master for the bank of clause registers.
- Accepts a clause-load job of up to MAX_NUMBER_OF_CLAUSES clauses and receives coefficients one variable per beat over a valid/ready stream.
- Packs each clause into a full coefficient vector, then broadcasts it with a one-cycle clause index so exactly one clause register captures it.
- Sits between the host/config interface and the clause register bank; index 0 is the bus idle value.

Parameters:
- BIT_WIDTH_OF_INTEGER_VARIABLE, 2, width of one coefficient.
- NUMBER_OF_INTEGER_VARIABLES, 2, coefficients per clause (beats per clause).
- MAX_NUMBER_OF_CLAUSES, 3, clause registers in the bank; identifiers 1..MAX.
- INDEX_WIDTH, 2, width of the clause index bus; must hold MAX_NUMBER_OF_CLAUSES.

Ports:
- in_clk  input  1  clock; all logic on posedge.
- in_reset_n  input  1  reset, asynchronous and active-low.
- in_start  input  1  one-cycle job start; honoured only in IDLE.
- in_num_clauses  input  INDEX_WIDTH  clauses to load; sampled on accepted in_start.
- in_valid  input  1  coefficient beat valid.
- in_coefficient  input  BIT_WIDTH_OF_INTEGER_VARIABLE  one variable's coefficient.
- out_ready  output  1  loader accepts a beat this cycle.
- out_clause_coefficients  output  BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES  packed clause to the bank.
- out_clause_index  output  INDEX_WIDTH  target register id; 0 means no write.
- out_busy  output  1  job in progress.
- out_done  output  1  one-cycle pulse when the job completes.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; beat and clause counters 0; pack register 0.
- States: IDLE, COLLECT, WRITE, DONE. All outputs are registered.
- IDLE:
  - out_busy=0, out_ready=0, out_clause_index=0.
  - in_start=1: latch N = min(in_num_clauses, MAX_NUMBER_OF_CLAUSES) and set clause counter to 1.
  - N=0 goes to DONE; otherwise goes to COLLECT.
- COLLECT:
  - out_ready=1, out_busy=1.
  - A beat transfers when in_valid && out_ready.
  - Beat k (0-based) writes bits [k*BW +: BW] of the pack register; beat 0 is the LSB slice.
  - When the accepted beat is beat NUMBER_OF_INTEGER_VARIABLES-1, go to WRITE. out_ready drops the next cycle, so no beat is accepted in WRITE.
- WRITE, held for exactly one cycle:
  - out_clause_coefficients = pack register; out_clause_index = clause counter.
  - Next cycle out_clause_index returns to 0. out_clause_coefficients holds its value until the next WRITE.
  - If clause counter == N, go to DONE. Otherwise increment the counter, clear the beat counter and go to COLLECT.
- Latency: last beat accepted at edge t, index nonzero during cycle t+1, target register captures at edge t+2.
- DONE: out_done=1 for one cycle, out_busy=0, then return to IDLE.
- in_start while busy (COLLECT/WRITE/DONE): ignored, no effect on the current job.
- in_valid in IDLE/WRITE/DONE: ignored, no data consumed.
- Reset asserted mid-job: job aborts immediately, outputs return to 0, no index pulse is issued. Partially loaded registers keep earlier writes.
- out_clause_index never exceeds N and is never nonzero for two consecutive cycles.

Optional Feature:
- Macro CLAUSE_LOADER_CLEAR_EN.
- Defined:
  - Adds state CLEAR, entered from IDLE on every accepted in_start (including N=0).
  - CLEAR drives out_clause_coefficients=0 and out_clause_index=1..MAX_NUMBER_OF_CLAUSES, one id per cycle.
  - Then proceeds to COLLECT, or to DONE if N=0. out_busy=1 and out_ready=0 during CLEAR.
  - Stale clauses beyond N are therefore zero.
- Undefined: no CLEAR state; start goes directly as described above.

Test Plan:
- Reset: hold in_reset_n=0 with in_start=1 and in_valid=1 -> all outputs 0; after release with inputs low, state stays IDLE.
- Single clause: start with in_num_clauses=1, beats 2'b01 then 2'b10 -> one cycle with out_clause_index=1 and out_clause_coefficients=4'b1001; out_done pulses the following cycle.
- Three clauses with in_valid toggling every other cycle: beats (1,2),(3,0),(2,2) -> index pulses 1,2,3 carrying 4'b1001, 4'b0011, 4'b1010; out_ready=0 in each WRITE cycle; exactly 3 nonzero index cycles.
- Boundaries:
  - in_num_clauses=0 -> out_done one cycle after start, no index pulse.
  - in_num_clauses=3 with MAX=3 -> last index is 3.
- Start while busy, then reset mid-job: in_start during COLLECT is ignored (N unchanged); async reset after beat 0 of clause 2 -> outputs 0 immediately and no index 2 pulse.
- With CLAUSE_LOADER_CLEAR_EN: start with N=1 -> indices 1,2,3 with coefficients 0 on consecutive cycles, then normal load of index 1.

Source files
------------

// File: rtl/clause_loader.sv
// Write-side master for the clause register bank: packs per-variable coefficient beats into a clause
// and broadcasts it with a one-cycle clause index. Optional CLAUSE_LOADER_CLEAR_EN zeroes all clauses on start.
module clause_loader #(
    parameter int BIT_WIDTH_OF_INTEGER_VARIABLE = 2,
    parameter int NUMBER_OF_INTEGER_VARIABLES   = 2,
    parameter int MAX_NUMBER_OF_CLAUSES         = 3,
    parameter int INDEX_WIDTH                   = 2
) (
    input  logic                                                           in_clk,
    input  logic                                                           in_reset_n,
    input  logic                                                           in_start,
    input  logic [INDEX_WIDTH-1:0]                                         in_num_clauses,
    input  logic                                                           in_valid,
    input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]                       in_coefficient,
    output logic                                                           out_ready,
    output logic [BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES-1:0] out_clause_coefficients,
    output logic [INDEX_WIDTH-1:0]                                         out_clause_index,
    output logic                                                           out_busy,
    output logic                                                           out_done
);

    localparam int BW  = BIT_WIDTH_OF_INTEGER_VARIABLE;
    localparam int NV  = NUMBER_OF_INTEGER_VARIABLES;
    localparam int CW  = BW * NV;
    localparam int BCW = (NV > 1) ? $clog2(NV) : 1;
    localparam logic [INDEX_WIDTH-1:0] MAX_IDX   = INDEX_WIDTH'(MAX_NUMBER_OF_CLAUSES);
    localparam logic [BCW-1:0]         LAST_BEAT = BCW'(NV - 1);

`ifdef CLAUSE_LOADER_CLEAR_EN
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, CLEAR} state_t;
    logic [INDEX_WIDTH-1:0] clear_q, clear_d;
`else
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
`endif

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] n_q, n_d;
    logic [INDEX_WIDTH-1:0] clause_q, clause_d;
    logic [BCW-1:0]         beat_q, beat_d;
    logic [CW-1:0]          pack_q, pack_d;
    logic [CW-1:0]          coef_q, coef_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            clause_q <= '0;
            beat_q   <= '0;
            pack_q   <= '0;
            coef_q   <= '0;
            index_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CLAUSE_LOADER_CLEAR_EN
            clear_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            clause_q <= clause_d;
            beat_q   <= beat_d;
            pack_q   <= pack_d;
            coef_q   <= coef_d;
            index_q  <= index_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef CLAUSE_LOADER_CLEAR_EN
            clear_q  <= clear_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        clause_d = clause_q;
        beat_d   = beat_q;
        pack_d   = pack_q;
        coef_d   = coef_q;
`ifdef CLAUSE_LOADER_CLEAR_EN
        clear_d  = clear_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_start) begin
                    n_d      = (in_num_clauses > MAX_IDX) ? MAX_IDX : in_num_clauses;
                    clause_d = INDEX_WIDTH'(1);
                    beat_d   = '0;
`ifdef CLAUSE_LOADER_CLEAR_EN
                    clear_d  = INDEX_WIDTH'(1);
                    state_d  = CLEAR;
`else
                    state_d  = (n_d == '0) ? DONE : COLLECT;
`endif
                end
            end
`ifdef CLAUSE_LOADER_CLEAR_EN
            CLEAR: begin
                if (clear_q == MAX_IDX) begin
                    state_d = (n_q == '0) ? DONE : COLLECT;
                end else begin
                    clear_d = clear_q + INDEX_WIDTH'(1);
                end
            end
`endif
            COLLECT: begin
                if (in_valid && ready_q) begin
                    pack_d[beat_q*BW +: BW] = in_coefficient;
                    if (beat_q == LAST_BEAT) begin
                        state_d = WRITE;
                    end else begin
                        beat_d = beat_q + BCW'(1);
                    end
                end
            end
            WRITE: begin
                if (clause_q == n_q) begin
                    state_d = DONE;
                end else begin
                    clause_d = clause_q + INDEX_WIDTH'(1);
                    beat_d   = '0;
                    state_d  = COLLECT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered: each flop is loaded with the value its next state implies.
        ready_d = (state_d == COLLECT);
        busy_d  = (state_d != IDLE) && (state_d != DONE);
        done_d  = (state_d == DONE);
        index_d = '0;
        if (state_d == WRITE) begin
            index_d = clause_d;
            coef_d  = pack_d;
        end
`ifdef CLAUSE_LOADER_CLEAR_EN
        if (state_d == CLEAR) begin
            index_d = clear_d;
            coef_d  = '0;
        end
`endif
    end

    assign out_ready               = ready_q;
    assign out_busy                = busy_q;
    assign out_done                = done_q;
    assign out_clause_index        = index_q;
    assign out_clause_coefficients = coef_q;

endmodule

// File: tb/tb_clause_loader.sv
// Scoreboard bench for clause_loader: expected index/clause pairs are queued as beats are driven
// and retired by a monitor whenever the DUT issues a nonzero clause index.
module tb_clause_loader;

    localparam int BW = 2;
    localparam int NV = 2;
    localparam int MC = 3;
    localparam int IW = 2;
    localparam int CW = BW * NV;
`ifdef CLAUSE_LOADER_CLEAR_EN
    localparam int CLR_LAT    = MC;
    localparam int CLR_PULSES = MC;
`else
    localparam int CLR_LAT    = 0;
    localparam int CLR_PULSES = 0;
`endif

    logic          in_clk;
    logic          in_reset_n;
    logic          in_start;
    logic [IW-1:0] in_num_clauses;
    logic          in_valid;
    logic [BW-1:0] in_coefficient;
    logic          out_ready;
    logic [CW-1:0] out_clause_coefficients;
    logic [IW-1:0] out_clause_index;
    logic          out_busy;
    logic          out_done;

    clause_loader #(
        .BIT_WIDTH_OF_INTEGER_VARIABLE (BW),
        .NUMBER_OF_INTEGER_VARIABLES   (NV),
        .MAX_NUMBER_OF_CLAUSES         (MC),
        .INDEX_WIDTH                   (IW)
    ) dut (
        .in_clk                  (in_clk),
        .in_reset_n              (in_reset_n),
        .in_start                (in_start),
        .in_num_clauses          (in_num_clauses),
        .in_valid                (in_valid),
        .in_coefficient          (in_coefficient),
        .out_ready               (out_ready),
        .out_clause_coefficients (out_clause_coefficients),
        .out_clause_index        (out_clause_index),
        .out_busy                (out_busy),
        .out_done                (out_done)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned pulses = 0;
    logic [IW+CW-1:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every nonzero index retires one scoreboard entry.
    logic [IW-1:0] prev_idx = '0;
    always @(negedge in_clk) begin
        logic [IW+CW-1:0] e;
        if (out_clause_index != '0) begin
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_idx", 32'(out_clause_index), 32'd0);
            end else begin
                e = sb.pop_front();
                check("idx", 32'(out_clause_index), 32'(e[IW+CW-1:CW]));
                check("coef", 32'(out_clause_coefficients), 32'(e[CW-1:0]));
                check("ready_in_write", 32'(out_ready), 32'd0);
                check("busy_in_write", 32'(out_busy), 32'd1);
            end
`ifndef CLAUSE_LOADER_CLEAR_EN
            check("idx_consecutive", 32'(prev_idx), 32'd0);
`endif
        end
        prev_idx = out_clause_index;
    end

    task automatic start_job(input logic [IW-1:0] n);
        in_start       = 1'b1;
        in_num_clauses = n;
`ifdef CLAUSE_LOADER_CLEAR_EN
        for (int i = 1; i <= MC; i++) sb.push_back({IW'(i), {CW{1'b0}}});
`endif
        @(negedge in_clk);
        in_start = 1'b0;
    endtask

    task automatic send_beat(input logic [BW-1:0] c, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge in_clk);
        in_valid       = 1'b1;
        in_coefficient = c;
        n = 0;
        while (!out_ready && n < 50) begin
            @(negedge in_clk);
            n++;
        end
        if (n >= 50) check("beat_timeout", 32'(n), 32'd0);
        @(negedge in_clk);
        in_valid = 1'b0;
    endtask

    task automatic load_clause(input logic [IW-1:0] idx, input logic [BW-1:0] c0,
                               input logic [BW-1:0] c1, input int gap);
        sb.push_back({idx, c1, c0});
        send_beat(c0, gap);
        send_beat(c1, gap);
    endtask

    task automatic expect_done(input int lat);
        int n;
        n = 0;
        while (!out_done && n < 20) begin
            @(negedge in_clk);
            n++;
        end
        check("done_lat", 32'(n), 32'(lat));
        @(negedge in_clk);
        check("done_pulse_end", 32'(out_done), 32'd0);
        check("idle_busy", 32'(out_busy), 32'd0);
    endtask

    initial begin
        int p0;
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        in_reset_n     = 1'b0;
        in_start       = 1'b1;
        in_valid       = 1'b1;
        in_num_clauses = 2'd3;
        in_coefficient = 2'd3;
        repeat (3) @(negedge in_clk);
        check("rst_outs", 32'({out_ready, out_busy, out_done, out_clause_index, out_clause_coefficients}), 32'd0);
        in_start = 1'b0;
        in_valid = 1'b0;
        in_reset_n = 1'b1;
        repeat (3) @(negedge in_clk);
        check("rst_idle", 32'({out_ready, out_busy, out_done, out_clause_index}), 32'd0);

        // Single clause.
        start_job(2'd1);
        load_clause(2'd1, 2'b01, 2'b10, 0);
        expect_done(1);

        // Three clauses, valid toggling.
        p0 = pulses;
        start_job(2'd3);
        load_clause(2'd1, 2'd1, 2'd2, 1);
        load_clause(2'd2, 2'd3, 2'd0, 1);
        load_clause(2'd3, 2'd2, 2'd2, 1);
        expect_done(1);
        check("pulse_count3", 32'(pulses - p0), 32'(3 + CLR_PULSES));

        // Zero clauses.
        p0 = pulses;
        start_job(2'd0);
        expect_done(CLR_LAT);
        check("pulse_count0", 32'(pulses - p0), 32'(CLR_PULSES));

        // Start while busy is ignored; reset mid clause 2 aborts.
        start_job(2'd2);
        sb.push_back({2'd1, 2'd0, 2'd3});
        send_beat(2'd3, 0);
        in_start       = 1'b1;
        in_num_clauses = 2'd1;
        @(negedge in_clk);
        in_start = 1'b0;
        send_beat(2'd0, 0);
        @(negedge in_clk);
        check("busy_after_c1", 32'({out_busy, out_done, out_ready}), 32'b101);
        send_beat(2'd1, 0);
        #2 in_reset_n = 1'b0;
        #1 check("rst_async", 32'({out_ready, out_busy, out_done, out_clause_index, out_clause_coefficients}), 32'd0);
        repeat (2) @(negedge in_clk);
        in_reset_n = 1'b1;
        repeat (4) @(negedge in_clk);
        check("post_rst_idle", 32'({out_busy, out_done, out_clause_index}), 32'd0);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
